// File: rtl/sram_row_controller.sv
// sram_row_controller
// Single-request sequencer for the SRAM word-row array. A request accepted in
// IDLE walks through PRE (bit-line precharge), ACC (word line held for
// ACCESS_CYCLES cycles, bit lines driven for writes, sampled for reads) and
// RSP (one-cycle response pulse), then returns to IDLE.
//
// Every output is a flop. Each one is loaded from a decode of the next state,
// so it lines up with the state register. A value decoded for a state is
// therefore visible for exactly the cycles the FSM spends in that state.

module sram_row_controller #(
    parameter int DEPTH         = 16,
    parameter int ADDR_W        = 4,
    parameter int DATA_W        = 32,
    parameter int ACCESS_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    output logic              rsp_err,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              precharge,
    output logic [DEPTH-1:0]  wl,
    output logic              bl_we,
    output logic [DATA_W-1:0] bl_wdata,
    input  logic [DATA_W-1:0] bl_rdata
);

    // The access counter counts down from ACCESS_CYCLES-1 to 0.
    localparam int CNT_W = (ACCESS_CYCLES > 1) ? $clog2(ACCESS_CYCLES) : 1;
    localparam logic [CNT_W-1:0]  CNT_LOAD  = CNT_W'(ACCESS_CYCLES - 1);
    localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0]  CNT_ZERO  = CNT_W'(0);
    localparam logic [ADDR_W:0]   DEPTH_LIM = (ADDR_W + 1)'(DEPTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PRE  = 2'd1,
        ACC  = 2'd2,
        RSP  = 2'd3
    } state_t;

    // One-hot row decode. It returns all zeros when the row is not enabled.
    function automatic logic [DEPTH-1:0] decode_row(input logic [ADDR_W-1:0] addr,
                                                    input logic              en);
        logic [DEPTH-1:0] rows;
        rows = {DEPTH{1'b0}};
        for (int i = 0; i < DEPTH; i++) begin
            rows[i] = en && (addr == ADDR_W'(i));
        end
        return rows;
    endfunction

    // Range check done once, when the request is captured.
    function automatic logic addr_in_range(input logic [ADDR_W-1:0] addr);
        return ({1'b0, addr} < DEPTH_LIM);
    endfunction

    state_t             state_r;
    state_t             state_s;
    logic [CNT_W-1:0]   cnt_r;
    logic [CNT_W-1:0]   cnt_s;
    logic               accept_s;

    // Request fields, frozen for the whole transaction.
    logic [ADDR_W-1:0]  addr_r;
    logic               we_r;
    logic [DATA_W-1:0]  wdata_r;
    logic               in_range_r;

    // Next-cycle output values
    logic               req_ready_s;
    logic               precharge_s;
    logic [DEPTH-1:0]   wl_s;
    logic               bl_we_s;
    logic [DATA_W-1:0]  bl_wdata_s;
    logic               rsp_valid_s;
    logic               rsp_err_s;
    logic [DATA_W-1:0]  rsp_rdata_s;

    assign accept_s = (state_r == IDLE) && req_valid && req_ready;

    // Next-state logic and access-hold countdown
    always_comb begin
        state_s = state_r;
        cnt_s   = cnt_r;
        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    state_s = PRE;
                end else begin
                    state_s = IDLE;
                end
            end
            PRE: begin
                state_s = ACC;
                cnt_s   = CNT_LOAD;
            end
            ACC: begin
                if (cnt_r == CNT_ZERO) begin
                    state_s = RSP;
                end else begin
                    state_s = ACC;
                    cnt_s   = cnt_r - CNT_ONE;
                end
            end
            RSP: begin
                state_s = IDLE;
            end
            default: begin
                state_s = IDLE;
                cnt_s   = CNT_ZERO;
            end
        endcase
    end

    // Output decode from the state being entered, so every output is registered
    always_comb begin
        req_ready_s = 1'b0;
        precharge_s = 1'b0;
        wl_s        = {DEPTH{1'b0}};
        bl_we_s     = 1'b0;
        bl_wdata_s  = {DATA_W{1'b0}};
        rsp_valid_s = 1'b0;
        rsp_err_s   = 1'b0;
        rsp_rdata_s = {DATA_W{1'b0}};
        case (state_s)
            IDLE: begin
                req_ready_s = 1'b1;
            end
            PRE: begin
                precharge_s = 1'b1;
            end
            ACC: begin
                // An out-of-range address keeps every row and the bit-line driver quiet
                wl_s = decode_row(addr_r, in_range_r);
                if (we_r && in_range_r) begin
                    bl_we_s    = 1'b1;
                    bl_wdata_s = wdata_r;
                end else begin
                    bl_we_s    = 1'b0;
                    bl_wdata_s = {DATA_W{1'b0}};
                end
            end
            RSP: begin
                // Entering RSP happens on the edge that ends the last ACC cycle,
                // while the selected row is still driving bl_rdata.
                rsp_valid_s = 1'b1;
                rsp_err_s   = !in_range_r;
                if (!we_r && in_range_r) begin
                    rsp_rdata_s = bl_rdata;
                end else begin
                    rsp_rdata_s = {DATA_W{1'b0}};
                end
            end
            default: begin
                req_ready_s = 1'b0;
            end
        endcase
    end

    // State register and access counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
            cnt_r   <= CNT_ZERO;
        end else begin
            state_r <= state_s;
            cnt_r   <= cnt_s;
        end
    end

    // Capture the request on the handshake and ignore later input changes
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_r     <= {ADDR_W{1'b0}};
            we_r       <= 1'b0;
            wdata_r    <= {DATA_W{1'b0}};
            in_range_r <= 1'b0;
        end else if (accept_s) begin
            addr_r     <= req_addr;
            we_r       <= req_we;
            wdata_r    <= req_wdata;
            in_range_r <= addr_in_range(req_addr);
        end
    end

    // Output registers. Reset clears the word line at once and aborts any access.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            req_ready <= 1'b1;
            precharge <= 1'b0;
            wl        <= {DEPTH{1'b0}};
            bl_we     <= 1'b0;
            bl_wdata  <= {DATA_W{1'b0}};
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            rsp_rdata <= {DATA_W{1'b0}};
        end else begin
            req_ready <= req_ready_s;
            precharge <= precharge_s;
            wl        <= wl_s;
            bl_we     <= bl_we_s;
            bl_wdata  <= bl_wdata_s;
            rsp_valid <= rsp_valid_s;
            rsp_err   <= rsp_err_s;
            rsp_rdata <= rsp_rdata_s;
        end
    end

endmodule
